// File: rtl/ulpi_reg_access.sv
// ULPI link-side register access engine: runs PHY register writes and reads
// (TX CMD, data phase, STP, turnaround) and shares the bus with receive traffic.
module ulpi_reg_access #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       req_i,
  input  logic       req_write_i,
  input  logic [5:0] req_addr_i,
  input  logic [7:0] req_wdata_i,
  output logic       busy_o,
  output logic       ack_o,
  output logic       err_o,
  output logic [7:0] rdata_o,
  input  logic       ulpi_dir_i,
  input  logic       ulpi_nxt_i,
  input  logic [7:0] ulpi_data_i,
  output logic [7:0] ulpi_data_o,
  output logic       ulpi_stp_o
);

  localparam logic [15:0] TIMEOUT = 16'(TIMEOUT_CYCLES);

  typedef enum logic [3:0] {
    IDLE, CMD, WDATA, STP, RTURN, RDATA, RWAIT, ABORT, DONE
  } state_t;

  state_t      state, state_next;
  logic [15:0] cnt, cnt_next, cnt_inc;
  logic        lat_write;
  logic [5:0]  lat_addr;
  logic [7:0]  lat_wdata;
  logic [7:0]  rd_buf;

  logic        busy_next, ack_next, err_next, stp_next;
  logic [7:0]  data_next, rdata_next;
  logic        accept, counted, timeout, capture;
  logic [7:0]  txcmd_in, txcmd_lat;

  assign accept    = req_i & ~busy_o;
  assign txcmd_in  = {1'b1, ~req_write_i, req_addr_i};
  assign txcmd_lat = {1'b1, ~lat_write, lat_addr};
  assign counted   = busy_o && (state != STP) && (state != DONE);
  assign cnt_inc   = (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
  assign timeout   = counted && (cnt_inc >= TIMEOUT);
  assign capture   = (state == RDATA) && ulpi_dir_i && !ulpi_nxt_i;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state       <= IDLE;
      cnt         <= '0;
      lat_write   <= 1'b0;
      lat_addr    <= '0;
      lat_wdata   <= '0;
      rd_buf      <= '0;
      busy_o      <= 1'b0;
      ack_o       <= 1'b0;
      err_o       <= 1'b0;
      rdata_o     <= '0;
      ulpi_data_o <= '0;
      ulpi_stp_o  <= 1'b0;
    end else begin
      state       <= state_next;
      cnt         <= cnt_next;
      busy_o      <= busy_next;
      ack_o       <= ack_next;
      err_o       <= err_next;
      rdata_o     <= rdata_next;
      ulpi_data_o <= data_next;
      ulpi_stp_o  <= stp_next;
      if (accept) begin
        lat_write <= req_write_i;
        lat_addr  <= req_addr_i;
        lat_wdata <= req_wdata_i;
      end
      if (capture) rd_buf <= ulpi_data_i;
    end
  end

  // The PHY owns the bus whenever dir is high, so dir beats nxt in the TX phases.
  always_comb begin
    state_next = state;
    if (timeout) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:  if ((accept || busy_o) && !ulpi_dir_i) state_next = CMD;
        CMD: begin
          if (ulpi_dir_i)      state_next = ABORT;
          else if (ulpi_nxt_i) state_next = lat_write ? WDATA : RTURN;
        end
        WDATA: begin
          if (ulpi_dir_i)      state_next = ABORT;
          else if (ulpi_nxt_i) state_next = STP;
        end
        STP:   state_next = DONE;
        RTURN: if (ulpi_dir_i) state_next = RDATA;
        RDATA: state_next = (!ulpi_dir_i || ulpi_nxt_i) ? ABORT : RWAIT;
        RWAIT: if (!ulpi_dir_i) state_next = DONE;
        ABORT: if (!ulpi_dir_i) state_next = CMD;
        DONE:  state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // Read data reaches rdata_o only when the read acks, so a timeout leaves it intact.
  always_comb begin
    busy_next  = busy_o;
    ack_next   = 1'b0;
    err_next   = 1'b0;
    stp_next   = 1'b0;
    data_next  = '0;
    rdata_next = rdata_o;
    cnt_next   = cnt;
    if (accept) begin
      busy_next = 1'b1;
      cnt_next  = '0;
    end else if (counted) begin
      cnt_next = cnt_inc;
    end
    if (timeout) begin
      busy_next = 1'b0;
      ack_next  = 1'b1;
      err_next  = 1'b1;
    end else begin
      case (state_next)
        CMD:   data_next = (state == IDLE && accept) ? txcmd_in : txcmd_lat;
        WDATA: data_next = lat_wdata;
        STP:   stp_next  = 1'b1;
        DONE: begin
          ack_next = 1'b1;
          if (!lat_write) rdata_next = rd_buf;
        end
        IDLE:  if (state == DONE) busy_next = 1'b0;
        default: data_next = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_ulpi_reg_access.sv
// Directed bench for ulpi_reg_access: writes, reads, throttling, PHY aborts,
// timeout, ignored requests and mid-transaction reset.
module tb_ulpi_reg_access;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b0;
  logic       req_i = 1'b0;
  logic       req_write_i = 1'b0;
  logic [5:0] req_addr_i = '0;
  logic [7:0] req_wdata_i = '0;
  logic       busy_o, ack_o, err_o;
  logic [7:0] rdata_o;
  logic       ulpi_dir_i = 1'b0;
  logic       ulpi_nxt_i = 1'b0;
  logic [7:0] ulpi_data_i = '0;
  logic [7:0] ulpi_data_o;
  logic       ulpi_stp_o;

  int checks = 0;
  int failures = 0;

  ulpi_reg_access #(.TIMEOUT_CYCLES(16)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_i(req_i), .req_write_i(req_write_i), .req_addr_i(req_addr_i),
    .req_wdata_i(req_wdata_i),
    .busy_o(busy_o), .ack_o(ack_o), .err_o(err_o), .rdata_o(rdata_o),
    .ulpi_dir_i(ulpi_dir_i), .ulpi_nxt_i(ulpi_nxt_i), .ulpi_data_i(ulpi_data_i),
    .ulpi_data_o(ulpi_data_o), .ulpi_stp_o(ulpi_stp_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input logic wr, input logic [5:0] addr, input logic [7:0] wdata);
    req_i = 1'b1;
    req_write_i = wr;
    req_addr_i = addr;
    req_wdata_i = wdata;
    tick();
    req_i = 1'b0;
  endtask

  task automatic wait_ack(input int max_cycles, output bit got);
    got = 1'b0;
    for (int i = 0; i < max_cycles && !got; i++) begin
      tick();
      if (ack_o) got = 1'b1;
    end
  endtask

  initial begin
    bit got;
    tick();
    tick();
    check_output("rst_busy", busy_o, 8'h0);
    check_output("rst_ack", ack_o, 8'h0);
    check_output("rst_err", err_o, 8'h0);
    check_output("rst_rdata", rdata_o, 8'h00);
    check_output("rst_data", ulpi_data_o, 8'h00);
    check_output("rst_stp", ulpi_stp_o, 8'h0);
    rst_i = 1'b1;
    tick();

    // Write 0x48 to 0x04 with no stalls
    apply_stimulus(1'b1, 6'h04, 8'h48);
    check_output("w1_busy", busy_o, 8'h1);
    check_output("w1_txcmd", ulpi_data_o, 8'h84);
    ulpi_nxt_i = 1'b1;
    tick();
    check_output("w1_wdata", ulpi_data_o, 8'h48);
    tick();
    check_output("w1_stp", ulpi_stp_o, 8'h1);
    check_output("w1_stp_data", ulpi_data_o, 8'h00);
    ulpi_nxt_i = 1'b0;
    tick();
    check_output("w1_ack", ack_o, 8'h1);
    check_output("w1_err", err_o, 8'h0);
    check_output("w1_stp_low", ulpi_stp_o, 8'h0);
    tick();
    check_output("w1_ack_pulse", ack_o, 8'h0);
    check_output("w1_idle", busy_o, 8'h0);

    // Read 0x0A, PHY returns 0x5A after one turnaround cycle
    apply_stimulus(1'b0, 6'h0A, 8'h00);
    check_output("r2_txcmd", ulpi_data_o, 8'hCA);
    ulpi_nxt_i = 1'b1;
    tick();
    check_output("r2_rturn_data", ulpi_data_o, 8'h00);
    ulpi_nxt_i = 1'b0;
    ulpi_dir_i = 1'b1;
    tick();
    ulpi_data_i = 8'h5A;
    tick();
    check_output("r2_rdata_held", rdata_o, 8'h00);
    ulpi_dir_i = 1'b0;
    ulpi_data_i = 8'h00;
    tick();
    check_output("r2_ack", ack_o, 8'h1);
    check_output("r2_err", err_o, 8'h0);
    check_output("r2_rdata", rdata_o, 8'h5A);
    tick();
    check_output("r2_idle", busy_o, 8'h0);

    // Write with nxt low for three cycles in CMD
    apply_stimulus(1'b1, 6'h05, 8'h11);
    for (int i = 0; i < 3; i++) begin
      check_output("w3_txcmd_hold", ulpi_data_o, 8'h85);
      tick();
    end
    check_output("w3_txcmd_hold4", ulpi_data_o, 8'h85);
    ulpi_nxt_i = 1'b1;
    tick();
    check_output("w3_wdata", ulpi_data_o, 8'h11);
    tick();
    check_output("w3_stp", ulpi_stp_o, 8'h1);
    ulpi_nxt_i = 1'b0;
    tick();
    check_output("w3_ack", ack_o, 8'h1);
    tick();

    // PHY takes the bus for five cycles during CMD
    apply_stimulus(1'b1, 6'h16, 8'h3C);
    check_output("w4_txcmd", ulpi_data_o, 8'h96);
    ulpi_dir_i = 1'b1;
    tick();
    check_output("w4_abort_data", ulpi_data_o, 8'h00);
    for (int i = 0; i < 4; i++) tick();
    check_output("w4_abort_busy", busy_o, 8'h1);
    check_output("w4_abort_stp", ulpi_stp_o, 8'h0);
    check_output("w4_abort_ack", ack_o, 8'h0);
    ulpi_dir_i = 1'b0;
    tick();
    check_output("w4_retry_txcmd", ulpi_data_o, 8'h96);
    ulpi_nxt_i = 1'b1;
    tick();
    check_output("w4_wdata", ulpi_data_o, 8'h3C);
    tick();
    check_output("w4_stp", ulpi_stp_o, 8'h1);
    ulpi_nxt_i = 1'b0;
    tick();
    check_output("w4_ack", ack_o, 8'h1);
    check_output("w4_err", err_o, 8'h0);
    tick();

    // Read that the PHY never acknowledges: 16 waiting cycles then error ack
    apply_stimulus(1'b0, 6'h01, 8'h00);
    check_output("t5_txcmd", ulpi_data_o, 8'hC1);
    for (int i = 0; i < 15; i++) tick();
    check_output("t5_no_ack_yet", ack_o, 8'h0);
    check_output("t5_still_busy", busy_o, 8'h1);
    tick();
    check_output("t5_ack", ack_o, 8'h1);
    check_output("t5_err", err_o, 8'h1);
    check_output("t5_busy", busy_o, 8'h0);
    check_output("t5_data", ulpi_data_o, 8'h00);
    check_output("t5_rdata_kept", rdata_o, 8'h5A);
    tick();
    check_output("t5_ack_pulse", ack_o, 8'h0);

    // Request while busy is ignored; reset during WDATA
    apply_stimulus(1'b1, 6'h07, 8'h99);
    check_output("s6_txcmd", ulpi_data_o, 8'h87);
    req_i = 1'b1;
    req_write_i = 1'b0;
    req_addr_i = 6'h3F;
    ulpi_nxt_i = 1'b1;
    tick();
    req_i = 1'b0;
    ulpi_nxt_i = 1'b0;
    check_output("s6_ignored_req", ulpi_data_o, 8'h99);
    rst_i = 1'b0;
    #1;
    check_output("s6_rst_data", ulpi_data_o, 8'h00);
    check_output("s6_rst_busy", busy_o, 8'h0);
    check_output("s6_rst_rdata", rdata_o, 8'h00);
    tick();
    rst_i = 1'b1;
    tick();
    check_output("s6_no_ack", ack_o, 8'h0);
    check_output("s6_no_stp", ulpi_stp_o, 8'h0);

    // Fresh write; dir and nxt together in CMD must abort, then complete
    apply_stimulus(1'b1, 6'h04, 8'h48);
    ulpi_dir_i = 1'b1;
    ulpi_nxt_i = 1'b1;
    tick();
    check_output("s6_dir_wins", ulpi_data_o, 8'h00);
    ulpi_dir_i = 1'b0;
    ulpi_nxt_i = 1'b0;
    tick();
    check_output("s6_retry_txcmd", ulpi_data_o, 8'h84);
    ulpi_nxt_i = 1'b1;
    wait_ack(10, got);
    ulpi_nxt_i = 1'b0;
    check_output("s6_ack_seen", 8'(got), 8'h1);
    check_output("s6_err", err_o, 8'h0);
    tick();
    check_output("s6_idle", busy_o, 8'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
